imem_fetch_responder: RTL

//  Instruction-memory responder: consumer end of the fetch interface driven by the PC logic.
//  - Accepts word fetch requests (addr, valid/ready) and returns the instruction word.
//  - Read latency is fixed; returned words are held in an in-order response FIFO with a

---
 rtl/imem_fetch_responder.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/imem_fetch_responder.sv
`default_nettype none
// ============================================================================
// Module   : imem_fetch_responder
// Purpose  : Instruction-memory responder at the consumer end of the PC fetch
//            interface. Fetches are read with a fixed latency into an in-order
//            response FIFO. Backpressure uses credits, so the FIFO cannot
//            overflow. A program-load write port fills the memory, and a flush
//            drops wrong-path fetches.
// Ports    : clk, rst                  clock, synchronous active-high reset
//            req_valid_i/req_ready_o   fetch handshake, req_addr_i = byte PC
//            flush_i                   drop every in-flight/buffered fetch
//            rsp_valid_o/rsp_ready_i   response handshake
//            rsp_instr_o/rsp_addr_o    returned word and its request address
//            rsp_err_o                 out-of-range (or misaligned) fetch
//            load_we_i/load_addr_i/load_data_i  program-load write port
// Options  : IMEM_MISALIGN_TRAP_EN - when defined, req_addr_i[1:0] != 0 yields
//            NOP_INSTR with rsp_err_o=1; otherwise the low bits are ignored.
// Revision : 1.0 - initial release
// ============================================================================
module imem_fetch_responder #(
    parameter int          DEPTH_WORDS = 256,
    parameter int          LATENCY     = 2,
    parameter int          FIFO_DEPTH  = 4,
    parameter logic [31:0] NOP_INSTR   = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [31:0] req_addr_i,
    input  logic        flush_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_instr_o,
    output logic [31:0] rsp_addr_o,
    output logic        rsp_err_o,
    input  logic        load_we_i,
    input  logic [31:0] load_addr_i,
    input  logic [31:0] load_data_i
);
    localparam int                 c_IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int                 c_PTR_W = $clog2(FIFO_DEPTH);
    localparam int                 c_CNT_W = c_PTR_W + 1;
    localparam logic [29:0]        c_DEPTH = 30'(DEPTH_WORDS);
    localparam logic [c_CNT_W-1:0] c_FULL  = c_CNT_W'(FIFO_DEPTH);

    logic [31:0]         mem_q [DEPTH_WORDS];

    // Read pipeline: stage 0 is loaded at the accept edge, the last stage
    // feeds the FIFO write, giving exactly LATENCY edges from accept to write.
    logic [LATENCY-1:0]  pipe_vld_q;
    logic [LATENCY-1:0]  pipe_err_q;
    logic [31:0]         pipe_instr_q [LATENCY];
    logic [31:0]         pipe_addr_q  [LATENCY];

    logic [31:0]         fifo_instr_q [FIFO_DEPTH];
    logic [31:0]         fifo_addr_q  [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] fifo_err_q;
    logic [c_PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [c_PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [c_CNT_W-1:0]  count_q, count_d;
    logic [c_CNT_W-1:0]  credits_q, credits_d;

    // Registered copy of the FIFO head; it keeps the last shown response when
    // the FIFO drains.
    logic [31:0]         rsp_instr_q, rsp_instr_d;
    logic [31:0]         rsp_addr_q, rsp_addr_d;
    logic                rsp_err_q, rsp_err_d;

    logic                w_accept;
    logic                w_pop;
    logic                w_fifo_wr;
    logic [29:0]         w_req_idx;
    logic [29:0]         w_load_idx;
    logic                w_misalign;
    logic                w_req_err;
    logic [31:0]         w_req_instr;
    logic [c_CNT_W-1:0]  w_cnt_after_pop;
    logic                w_unused;

    assign req_ready_o = !rst && !flush_i && (credits_q != '0);
    assign rsp_valid_o = (count_q != '0);
    assign rsp_instr_o = rsp_instr_q;
    assign rsp_addr_o  = rsp_addr_q;
    assign rsp_err_o   = rsp_err_q;

    assign w_accept   = req_valid_i && req_ready_o;
    assign w_pop      = rsp_valid_o && rsp_ready_i;
    assign w_fifo_wr  = pipe_vld_q[LATENCY-1];
    assign w_req_idx  = req_addr_i[31:2];
    assign w_load_idx = load_addr_i[31:2];

`ifdef IMEM_MISALIGN_TRAP_EN
    assign w_misalign = (req_addr_i[1:0] != 2'b00);
`else
    assign w_misalign = 1'b0;
`endif

    assign w_req_err   = (w_req_idx >= c_DEPTH) || w_misalign;
    assign w_req_instr = w_req_err ? NOP_INSTR : mem_q[w_req_idx[c_IDX_W-1:0]];

    // Byte-offset bits that play no part in word addressing.
    assign w_unused = ^{req_addr_i[1:0], load_addr_i[1:0]};

    always_comb begin
        credits_d       = credits_q + c_CNT_W'(w_pop) - c_CNT_W'(w_accept);
        count_d         = count_q + c_CNT_W'(w_fifo_wr) - c_CNT_W'(w_pop);
        rd_ptr_d        = rd_ptr_q + c_PTR_W'(w_pop);
        wr_ptr_d        = wr_ptr_q + c_PTR_W'(w_fifo_wr);
        w_cnt_after_pop = count_q - c_CNT_W'(w_pop);
        rsp_instr_d     = rsp_instr_q;
        rsp_addr_d      = rsp_addr_q;
        rsp_err_d       = rsp_err_q;
        // The head after this edge is either an already-stored entry, or the
        // word being written right now when nothing else remains in the FIFO.
        if (w_cnt_after_pop != '0) begin
            rsp_instr_d = fifo_instr_q[rd_ptr_d];
            rsp_addr_d  = fifo_addr_q[rd_ptr_d];
            rsp_err_d   = fifo_err_q[rd_ptr_d];
        end else if (w_fifo_wr) begin
            rsp_instr_d = pipe_instr_q[LATENCY-1];
            rsp_addr_d  = pipe_addr_q[LATENCY-1];
            rsp_err_d   = pipe_err_q[LATENCY-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pipe_vld_q  <= '0;
            count_q     <= '0;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            credits_q   <= c_FULL;
            rsp_instr_q <= '0;
            rsp_addr_q  <= '0;
            rsp_err_q   <= 1'b0;
        end else if (flush_i) begin
            pipe_vld_q  <= '0;
            count_q     <= '0;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            credits_q   <= c_FULL;
        end else begin
            pipe_vld_q[0] <= w_accept;
            for (int i = 1; i < LATENCY; i++) begin
                pipe_vld_q[i] <= pipe_vld_q[i-1];
            end
            count_q     <= count_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            credits_q   <= credits_d;
            rsp_instr_q <= rsp_instr_d;
            rsp_addr_q  <= rsp_addr_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    // Pipeline payload needs no reset; the valid bits qualify it. Stage 0
    // samples the memory before this edge's load write lands, which gives
    // read-before-write behaviour for a same-cycle fetch of the loaded word.
    always_ff @(posedge clk) begin
        pipe_instr_q[0] <= w_req_instr;
        pipe_addr_q[0]  <= req_addr_i;
        pipe_err_q[0]   <= w_req_err;
        for (int i = 1; i < LATENCY; i++) begin
            pipe_instr_q[i] <= pipe_instr_q[i-1];
            pipe_addr_q[i]  <= pipe_addr_q[i-1];
            pipe_err_q[i]   <= pipe_err_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && !flush_i && w_fifo_wr) begin
            fifo_instr_q[wr_ptr_q] <= pipe_instr_q[LATENCY-1];
            fifo_addr_q[wr_ptr_q]  <= pipe_addr_q[LATENCY-1];
            fifo_err_q[wr_ptr_q]   <= pipe_err_q[LATENCY-1];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && load_we_i && (w_load_idx < c_DEPTH)) begin
            mem_q[w_load_idx[c_IDX_W-1:0]] <= load_data_i;
        end
    end

endmodule
`default_nettype wire
